cdc_handshake_sync: RTL
=======================

Name: cdc_handshake_sync

Overview:
- Parametrised clock-domain-crossing block: moves a WIDTH-bit word from clk_a to clk_b with a req/ack handshake.
- Replaces the bare flop-to-flop crossing with properly synchronised control and quasi-static data.
- Supports 2-phase (toggle) and 4-phase (level) protocols, selected by parameter.
- Sits at every single-word control/status crossing between the clk_a and clk_b domains of the chip.

Parameters:
- WIDTH, 8: data word width in bits, 1..64.
- SYNC_STAGES, 2: flops in each req/ack synchroniser, 2..4.
- FOUR_PHASE, 0: 0 = 2-phase toggle protocol; 1 = 4-phase return-to-zero protocol.

Ports:
- clk_a  input  1  source-domain clock.
- rst_a_n  input  1  source-domain reset, asynchronous, active-low.
- clk_b  input  1  destination-domain clock.
- rst_b_n  input  1  destination-domain reset, asynchronous, active-low.
- in_valid  input  1  clk_a: source offers in_data.
- in_ready  output  1  clk_a: block accepts a word this cycle.
- in_data  input  WIDTH  clk_a: word to transfer.
- busy_a  output  1  clk_a: a transfer is outstanding (equals !in_ready).
- out_valid  output  1  clk_b: out_data holds a new word.
- out_ready  input  1  clk_b: sink consumes the word.
- out_data  output  WIDTH  clk_b: transferred word.

Behaviour:
- Reset values:
  - rst_a_n low: in_ready=1, busy_a=0, req_a=0, hold_a=0, ack synchroniser=0.
  - rst_b_n low: out_valid=0, out_data=0, ack_b=0, req synchroniser=0.
- Crossing signals: only req_a (to clk_b), ack_b (to clk_a) and hold_a (quasi-static data).
  - Each synchroniser is SYNC_STAGES flops, reset by its destination-domain reset.
  - hold_a is never sampled by clk_b logic unless the synchronised req has changed. It is stable from the req change until ack returns.
- Source FSM, clk_a:
  - States IDLE, WAIT_ACK, and WAIT_ACK_LOW (4-phase only).
  - IDLE: in_ready=1. On in_valid&&in_ready: hold_a<=in_data; req_a toggles (2-phase) or goes 1 (4-phase); next state WAIT_ACK; in_ready=0 from the next cycle.
  - WAIT_ACK, 2-phase: when ack_sync_a==req_a, go to IDLE.
  - WAIT_ACK, 4-phase: when ack_sync_a==1, req_a<=0 and go to WAIT_ACK_LOW.
  - WAIT_ACK_LOW: when ack_sync_a==0, go to IDLE.
- Destination FSM, clk_b:
  - States IDLE, HOLD, and WAIT_REQ_LOW (4-phase only).
  - IDLE: new request detected when req_sync_b != req_seen_b (2-phase) or req_sync_b==1 (4-phase). Then out_data<=hold_a, out_valid<=1, go to HOLD.
  - HOLD: out_valid and out_data stay stable until out_valid&&out_ready. On that cycle out_valid<=0.
    - 2-phase: ack_b toggles to equal req_seen_b; go to IDLE.
    - 4-phase: ack_b<=1; go to WAIT_REQ_LOW.
  - WAIT_REQ_LOW: when req_sync_b==0, ack_b<=0 and go to IDLE.
- Latency:
  - Accept edge to out_valid rise: SYNC_STAGES+1 clk_b edges, +1 clk_b edge of phase uncertainty.
  - out_ready handshake to in_ready rise: SYNC_STAGES+1 clk_a edges, +1 of uncertainty.
  - 4-phase adds one further round trip.
- Throughput: at most one word in flight; no buffering, no data loss, no duplication.
- in_data and in_valid changes while in_ready=0 are ignored. in_valid need not be held after acceptance.
- out_ready asserted while out_valid=0 has no effect.
- Simultaneous in_valid with in_ready rising: accepted in the cycle in_ready is 1.
- Resets:
  - Both resets must be asserted together, with overlap of at least SYNC_STAGES cycles of the slower clock. After this, the block is idle and consistent.
  - A one-sided reset mid-transfer forces only that domain's outputs to reset values. A word in flight may be lost. Recovery requires a joint reset.
- Timing constraints: hold_a->out_data is a max-delay path of one clk_b period; synchroniser first stages are false paths.

Test Plan:
- 2-phase, WIDTH=8, clk_a=100MHz, clk_b=37MHz: send 0xA5 with out_ready=1 -> out_data=0xA5, out_valid pulses for 1 clk_b cycle, in_ready returns after ack; exactly one word out.
- 2-phase back-to-back: in_valid held high with words 0x01..0x10 -> 16 words out in order, no drop or duplicate; in_ready low while each word is outstanding.
- 4-phase, WIDTH=32: send 0xDEADBEEF -> same word out; req_a/ack_b each show one rise and one fall per word; in_ready rises only after ack_sync_a returns to 0.
- Sink stall: out_ready=0 for 50 clk_b cycles after out_valid -> out_data stays stable, in_ready stays 0, in_data changes ignored; release -> word delivered once.
- Clock ratio sweep clk_b/clk_a in {0.1, 1.0 with phase offset, 7.3}, SYNC_STAGES in {2, 3}, random data, 1000 words -> scoreboard matches; latency within the stated bound.
- Joint reset asserted while in HOLD -> out_valid=0, in_ready=1 after release; a following word 0x3C transfers correctly.

Source files
------------

// File: rtl/cdc_handshake_sync.sv
// cdc_handshake_sync
//   Moves one WIDTH-bit word from clk_a to clk_b using a req/ack handshake.
//   The data word is parked in hold_a and stays quasi-static while a request is
//   outstanding. Only req_a, ack_b and hold_a cross between the domains; req and
//   ack each pass through a SYNC_STAGES-deep synchroniser in the receiving domain.
//   FOUR_PHASE = 0 selects the toggle (2-phase) protocol, 1 the return-to-zero
//   (4-phase) protocol.
//
// Ports
//   clk_a, rst_a_n   source clock / async active-low reset
//   clk_b, rst_b_n   destination clock / async active-low reset
//   in_valid         clk_a: source offers in_data
//   in_ready         clk_a: block accepts a word this cycle
//   in_data          clk_a: word to transfer
//   busy_a           clk_a: transfer outstanding (= !in_ready)
//   out_valid        clk_b: out_data holds a new word
//   out_ready        clk_b: sink consumes the word
//   out_data         clk_b: transferred word
module cdc_handshake_sync #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FOUR_PHASE  = 0
) (
   input  logic             clk_a,
   input  logic             rst_a_n,
   input  logic             clk_b,
   input  logic             rst_b_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             busy_a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam bit four_ph = (FOUR_PHASE != 0);

   typedef enum logic [1:0] {SrcIdle, SrcWaitAck, SrcWaitAckLow} src_state_e;
   typedef enum logic [1:0] {DstIdle, DstHold, DstWaitReqLow} dst_state_e;

   // ---------------------------------------------------------------- clk_a side
   src_state_e             src_state;
   logic                   ready_a;
   logic                   req_a;
   logic [WIDTH-1:0]       hold_a;
   logic [SYNC_STAGES-1:0] ack_sync_pipe_a;
   logic                   ack_sync_a;

   // ---------------------------------------------------------------- clk_b side
   dst_state_e             dst_state;
   logic                   valid_b;
   logic [WIDTH-1:0]       data_b;
   logic                   ack_b;
   logic                   req_seen_b;
   logic [SYNC_STAGES-1:0] req_sync_pipe_b;
   logic                   req_sync_b;
   logic                   new_req_b;

   // ack_b into clk_a; the first stage is the only flop that may go metastable.
   always_ff @(posedge clk_a or negedge rst_a_n) begin
      if (!rst_a_n) begin
         ack_sync_pipe_a <= '0;
      end else begin
         ack_sync_pipe_a <= {ack_sync_pipe_a[SYNC_STAGES-2:0], ack_b};
      end
   end
   assign ack_sync_a = ack_sync_pipe_a[SYNC_STAGES-1];

   // Source FSM. hold_a is only loaded in SrcIdle, so it is stable for the whole
   // time the destination may sample it.
   always_ff @(posedge clk_a or negedge rst_a_n) begin
      if (!rst_a_n) begin
         src_state <= SrcIdle;
         ready_a   <= 1'b1;
         req_a     <= 1'b0;
         hold_a    <= '0;
      end else begin
         case (src_state)
            SrcIdle: begin
               if (in_valid) begin
                  hold_a    <= in_data;
                  req_a     <= four_ph ? 1'b1 : ~req_a;
                  ready_a   <= 1'b0;
                  src_state <= SrcWaitAck;
               end
            end
            SrcWaitAck: begin
               if (four_ph) begin
                  if (ack_sync_a) begin
                     req_a     <= 1'b0;
                     src_state <= SrcWaitAckLow;
                  end
               end else if (ack_sync_a == req_a) begin
                  ready_a   <= 1'b1;
                  src_state <= SrcIdle;
               end
            end
            SrcWaitAckLow: begin
               if (!ack_sync_a) begin
                  ready_a   <= 1'b1;
                  src_state <= SrcIdle;
               end
            end
            default: begin
               ready_a   <= 1'b1;
               src_state <= SrcIdle;
            end
         endcase
      end
   end

   assign in_ready = ready_a;
   assign busy_a   = ~ready_a;

   // req_a into clk_b.
   always_ff @(posedge clk_b or negedge rst_b_n) begin
      if (!rst_b_n) begin
         req_sync_pipe_b <= '0;
      end else begin
         req_sync_pipe_b <= {req_sync_pipe_b[SYNC_STAGES-2:0], req_a};
      end
   end
   assign req_sync_b = req_sync_pipe_b[SYNC_STAGES-1];

   assign new_req_b = four_ph ? req_sync_b : (req_sync_b != req_seen_b);

   // Destination FSM. hold_a is captured only on a detected request edge, when
   // it has been stable for at least SYNC_STAGES clk_b cycles.
   always_ff @(posedge clk_b or negedge rst_b_n) begin
      if (!rst_b_n) begin
         dst_state  <= DstIdle;
         valid_b    <= 1'b0;
         data_b     <= '0;
         ack_b      <= 1'b0;
         req_seen_b <= 1'b0;
      end else begin
         case (dst_state)
            DstIdle: begin
               if (new_req_b) begin
                  data_b     <= hold_a;
                  valid_b    <= 1'b1;
                  req_seen_b <= req_sync_b;
                  dst_state  <= DstHold;
               end
            end
            DstHold: begin
               if (out_ready) begin
                  valid_b <= 1'b0;
                  if (four_ph) begin
                     ack_b     <= 1'b1;
                     dst_state <= DstWaitReqLow;
                  end else begin
                     ack_b     <= req_seen_b;
                     dst_state <= DstIdle;
                  end
               end
            end
            DstWaitReqLow: begin
               if (!req_sync_b) begin
                  ack_b     <= 1'b0;
                  dst_state <= DstIdle;
               end
            end
            default: begin
               valid_b   <= 1'b0;
               dst_state <= DstIdle;
            end
         endcase
      end
   end

   assign out_valid = valid_b;
   assign out_data  = data_b;

endmodule
